// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-ported memory between the fetch and data ports.
// Each access runs a req/ack handshake, returns a one-cycle ready pulse, and aborts with err on timeout.
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TO_W    = 8
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ready,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [3:0]  d_be,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic        err,
    output logic        m_req,
    output logic        m_we,
    output logic [3:0]  m_be,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    input  logic        m_ack
);
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned BW = 4;

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t          state, state_nx;
    logic            last_d, last_d_nx;
    logic            gnt_d, gnt_d_nx;
    logic [TO_W-1:0] cnt, cnt_nx;
    logic            pick_d;
    logic            m_req_nx, m_we_nx;
    logic [BW-1:0]   m_be_nx;
    logic [AW-1:0]   m_addr_nx;
    logic [DW-1:0]   m_wdata_nx, i_rdata_nx, d_rdata_nx;
    logic            i_ready_nx, d_ready_nx, err_nx;

    // State and all outputs registered
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state   <= IDLE;
            last_d  <= 1'b0;
            gnt_d   <= 1'b0;
            cnt     <= '0;
            m_req   <= 1'b0;
            m_we    <= 1'b0;
            m_be    <= '0;
            m_addr  <= '0;
            m_wdata <= '0;
            i_rdata <= '0;
            d_rdata <= '0;
            i_ready <= 1'b0;
            d_ready <= 1'b0;
            err     <= 1'b0;
        end else begin
            state   <= state_nx;
            last_d  <= last_d_nx;
            gnt_d   <= gnt_d_nx;
            cnt     <= cnt_nx;
            m_req   <= m_req_nx;
            m_we    <= m_we_nx;
            m_be    <= m_be_nx;
            m_addr  <= m_addr_nx;
            m_wdata <= m_wdata_nx;
            i_rdata <= i_rdata_nx;
            d_rdata <= d_rdata_nx;
            i_ready <= i_ready_nx;
            d_ready <= d_ready_nx;
            err     <= err_nx;
        end
    end

    // Next-state and next-output logic; ready/err are pulses so they default low
    always_comb begin
        state_nx   = state;
        last_d_nx  = last_d;
        gnt_d_nx   = gnt_d;
        cnt_nx     = cnt;
        pick_d     = 1'b0;
        m_req_nx   = m_req;
        m_we_nx    = m_we;
        m_be_nx    = m_be;
        m_addr_nx  = m_addr;
        m_wdata_nx = m_wdata;
        i_rdata_nx = i_rdata;
        d_rdata_nx = d_rdata;
        i_ready_nx = 1'b0;
        d_ready_nx = 1'b0;
        err_nx     = 1'b0;

        case (state)
            IDLE: begin
                if (i_req || d_req) begin
                    // On a tie, the port that did not win last time goes first
                    pick_d    = d_req && (!i_req || !last_d);
                    gnt_d_nx  = pick_d;
                    last_d_nx = pick_d;
                    cnt_nx    = '0;
                    m_req_nx  = 1'b1;
                    if (pick_d) begin
                        m_we_nx    = d_we;
                        m_be_nx    = d_we ? d_be : {BW{1'b1}};
                        m_addr_nx  = d_addr;
                        m_wdata_nx = d_wdata;
                    end else begin
                        m_we_nx    = 1'b0;
                        m_be_nx    = {BW{1'b1}};
                        m_addr_nx  = i_addr;
                        m_wdata_nx = '0;
                    end
                    state_nx = ISSUE;
                end
            end
            ISSUE: begin
                if (m_ack) begin
                    m_req_nx = 1'b0;
                    if (gnt_d) begin
                        d_ready_nx = 1'b1;
                        if (!m_we) d_rdata_nx = m_rdata;
                    end else begin
                        i_ready_nx = 1'b1;
                        i_rdata_nx = m_rdata;
                    end
                    state_nx = RESP;
                end else if (cnt == TO_W'(TIMEOUT - 1)) begin
                    m_req_nx = 1'b0;
                    err_nx   = 1'b1;
                    if (gnt_d) begin
                        d_ready_nx = 1'b1;
                        d_rdata_nx = '0;
                    end else begin
                        i_ready_nx = 1'b1;
                        i_rdata_nx = '0;
                    end
                    state_nx = RESP;
                end else begin
                    cnt_nx = cnt + TO_W'(1);
                end
            end
            RESP: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: the bench plays the memory and checks outputs 1 time unit after each rising edge.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        clr;
    logic        i_req, d_req, d_we, m_ack;
    logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
    logic [3:0]  d_be;
    logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
    logic        i_ready, d_ready, err, m_req, m_we;
    logic [3:0]  m_be;

    int total = 0;
    int bad   = 0;

    mem_arbiter #(.TIMEOUT(8), .TO_W(8)) dut (
        .clk(clk), .clr(clr),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready), .err(err),
        .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ack(m_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Mutual exclusion of the ready pulses and err qualification, checked mid-cycle
    always @(negedge clk) begin
        if (clr) begin
            chk("one_ready", 32'(i_ready & d_ready), 32'd0);
            chk("err_qual", 32'(err & ~(i_ready | d_ready)), 32'd0);
        end
    end

    initial begin
        clr = 1'b0; i_req = 0; d_req = 0; d_we = 0; m_ack = 0;
        i_addr = 0; d_addr = 0; d_wdata = 0; m_rdata = 0; d_be = 0;
        tick(); tick();
        chk("rst_m_req", 32'(m_req), 32'd0);
        chk("rst_i_ready", 32'(i_ready), 32'd0);
        chk("rst_d_ready", 32'(d_ready), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_i_rdata", i_rdata, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        clr = 1'b1;
        tick();

        // Single fetch, memory acks in the first ISSUE cycle
        i_req = 1; i_addr = 32'h100; m_ack = 1; m_rdata = 32'h00500113;
        tick();
        chk("f_m_req", 32'(m_req), 32'd1);
        chk("f_m_addr", m_addr, 32'h100);
        chk("f_m_be", 32'(m_be), 32'hF);
        chk("f_m_we", 32'(m_we), 32'd0);
        chk("f_early_rdy", 32'(i_ready), 32'd0);
        tick();
        chk("f_i_ready", 32'(i_ready), 32'd1);
        chk("f_i_rdata", i_rdata, 32'h00500113);
        chk("f_err", 32'(err), 32'd0);
        chk("f_m_req_drop", 32'(m_req), 32'd0);
        i_req = 0; m_ack = 0;
        tick();
        chk("f_rdy_clear", 32'(i_ready), 32'd0);

        // Store with four wait cycles
        d_req = 1; d_we = 1; d_be = 4'b0011; d_addr = 32'h2004; d_wdata = 32'hCAFEBABE;
        tick();
        for (int k = 0; k < 5; k++) begin
            chk("s_m_req", 32'(m_req), 32'd1);
            chk("s_m_we", 32'(m_we), 32'd1);
            chk("s_m_be", 32'(m_be), 32'h3);
            chk("s_m_addr", m_addr, 32'h2004);
            chk("s_m_wdata", m_wdata, 32'hCAFEBABE);
            chk("s_no_rdy", 32'(d_ready), 32'd0);
            if (k < 4) tick();
        end
        m_ack = 1; m_rdata = 32'hDEADBEEF;
        tick();
        chk("s_d_ready", 32'(d_ready), 32'd1);
        chk("s_err", 32'(err), 32'd0);
        chk("s_d_rdata", d_rdata, 32'd0);
        d_req = 0; d_we = 0; m_ack = 0;
        tick();

        // Asynchronous reset in the middle of an access
        i_req = 1; i_addr = 32'h300;
        tick();
        chk("r_m_req_pre", 32'(m_req), 32'd1);
        #2 clr = 1'b0;
        #1;
        chk("r_m_req", 32'(m_req), 32'd0);
        chk("r_m_addr", m_addr, 32'd0);
        chk("r_m_be", 32'(m_be), 32'd0);
        chk("r_m_we", 32'(m_we), 32'd0);
        tick();
        chk("r_no_rdy", 32'(i_ready), 32'd0);
        #2 clr = 1'b1;
        tick();
        chk("r_regrant", 32'(m_req), 32'd1);
        chk("r_regrant_a", m_addr, 32'h300);
        m_ack = 1; m_rdata = 32'h0000AAAA;
        tick();
        chk("r_i_ready", 32'(i_ready), 32'd1);
        i_req = 0;
        tick();

        // Contention with immediate ack: D first (last grant was I), then alternating every 3 cycles
        i_req = 1; i_addr = 32'h800; d_req = 1; d_we = 0; d_addr = 32'h400; m_rdata = 32'h11112222;
        for (int g = 0; g < 4; g++) begin
            tick();
            chk("c_m_req", 32'(m_req), 32'd1);
            chk("c_m_addr", m_addr, (g % 2 == 0) ? 32'h400 : 32'h800);
            tick();
            chk("c_d_ready", 32'(d_ready), (g % 2 == 0) ? 32'd1 : 32'd0);
            chk("c_i_ready", 32'(i_ready), (g % 2 == 0) ? 32'd0 : 32'd1);
            tick();
            chk("c_gap_req", 32'(m_req), 32'd0);
            chk("c_gap_rdy", 32'(i_ready | d_ready), 32'd0);
        end
        chk("c_d_rdata", d_rdata, 32'h11112222);
        i_req = 0; d_req = 0; m_ack = 0;

        // Timeout on a load: m_req high for 8 cycles, then err pulse with zero data
        d_req = 1; d_we = 0; d_addr = 32'h500;
        tick();
        for (int k = 0; k < 8; k++) begin
            chk("t_m_req", 32'(m_req), 32'd1);
            chk("t_no_rdy", 32'(d_ready), 32'd0);
            if (k < 7) tick();
        end
        tick();
        chk("t_m_req_drop", 32'(m_req), 32'd0);
        chk("t_d_ready", 32'(d_ready), 32'd1);
        chk("t_err", 32'(err), 32'd1);
        chk("t_d_rdata", d_rdata, 32'd0);
        d_req = 0; i_req = 1; i_addr = 32'h600; m_ack = 1; m_rdata = 32'h0BADC0DE;
        tick();
        chk("t_err_clear", 32'(err), 32'd0);
        chk("t_rdy_clear", 32'(d_ready), 32'd0);
        tick();
        chk("t_next_addr", m_addr, 32'h600);
        tick();
        chk("t_next_rdy", 32'(i_ready), 32'd1);
        chk("t_next_err", 32'(err), 32'd0);
        chk("t_next_rdata", i_rdata, 32'h0BADC0DE);

        // Fetch requester drops req mid-access
        i_addr = 32'h700; m_ack = 0;
        tick();
        tick();
        chk("d_m_req", 32'(m_req), 32'd1);
        chk("d_m_addr", m_addr, 32'h700);
        i_req = 0;
        tick();
        chk("d_hold", 32'(m_req), 32'd1);
        m_ack = 1; m_rdata = 32'h00000013;
        tick();
        chk("d_i_ready", 32'(i_ready), 32'd1);
        chk("d_i_rdata", i_rdata, 32'h00000013);
        m_ack = 0;
        tick();
        chk("d_rdy_once", 32'(i_ready), 32'd0);
        tick();
        chk("d_no_regrant", 32'(m_req), 32'd0);
        tick();
        chk("d_no_regrant2", 32'(m_req), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
